sm3_expnd_core: RTL and testbench

SM3_EXPND_CORE -- requirements
Module: sm3_expnd_core

---
 rtl/sm3_expnd_core.sv | 98 +++++++++
 tb/tb_sm3_expnd_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_expnd_core.sv
// sm3_expnd_core: SM3 message expansion. Padded words are collected in a
// 16-word staging buffer. Each full block is copied into a sliding window
// that produces one W_j / W'_j pair per cycle for rounds 0..63.
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   pad_d_i/vld/lst     padded word stream (no stall); lst marks the message's last word
//   pad_ena_o           staging buffer can accept another word
//   expnd_w_o/w1_o      W_j and W'_j for the current round
//   expnd_vld_o/rnd_o   round valid and round index j
//   expnd_sop_o/lst_o   round 0 of any block / round 63 of the final block
//   err_o               sticky protocol error (overflow or misplaced lst)
module sm3_expnd_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pad_d_i,
    input  logic        pad_vld_i,
    input  logic        pad_lst_i,
    output logic        pad_ena_o,
    output logic [31:0] expnd_w_o,
    output logic [31:0] expnd_w1_o,
    output logic        expnd_vld_o,
    output logic [5:0]  expnd_rnd_o,
    output logic        expnd_sop_o,
    output logic        expnd_lst_o,
    output logic        err_o
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state_q, state_d;
    logic [31:0] stage_q [16];
    logic [31:0] stage_d [16];
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [4:0]  stage_cnt_q, stage_cnt_d;
    logic        stage_lst_q, stage_lst_d;
    logic        blk_lst_q, blk_lst_d;
    logic        err_q, err_d;
    logic [5:0]  rnd_q, rnd_d;
    logic        accept, xfer, last_rnd;
    logic [31:0] p1_in, new_w;

    always_comb begin
        accept   = pad_vld_i && stage_cnt_q != 5'd16;
        last_rnd = state_q == EXPAND && rnd_q == 6'd63;
        // A full stage moves into the window when idle or as the current block ends,
        // so consecutive blocks stream without a bubble.
        xfer     = stage_cnt_q == 5'd16 && (state_q == IDLE || last_rnd);
        p1_in    = win_q[0] ^ win_q[7] ^ {win_q[13][16:0], win_q[13][31:17]};
        new_w    = p1_in ^ {p1_in[16:0], p1_in[31:17]} ^ {p1_in[8:0], p1_in[31:9]}
                 ^ {win_q[3][24:0], win_q[3][31:25]} ^ win_q[10];
        stage_d = stage_q;
        if (accept)
            stage_d[stage_cnt_q[3:0]] = pad_d_i;
        stage_cnt_d = xfer ? 5'd0 : stage_cnt_q + 5'(accept);
        stage_lst_d = xfer ? 1'b0 : stage_lst_q | (accept & pad_lst_i);
        blk_lst_d   = xfer ? stage_lst_q : blk_lst_q;
        err_d       = err_q | (pad_vld_i & ~accept)
                    | (accept & pad_lst_i & (stage_cnt_q != 5'd15));
        state_d     = xfer ? EXPAND : last_rnd ? IDLE : state_q;
        rnd_d       = xfer ? 6'd0 : state_q == EXPAND ? rnd_q + 6'd1 : rnd_q;
        for (int i = 0; i < 15; i++)
            win_d[i] = xfer ? stage_q[i] : state_q == EXPAND ? win_q[i+1] : win_q[i];
        win_d[15] = xfer ? stage_q[15] : state_q == EXPAND ? new_w : win_q[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_cnt_q <= '0;
            stage_lst_q <= 1'b0;
            blk_lst_q   <= 1'b0;
            err_q       <= 1'b0;
            rnd_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                stage_q[i] <= '0;
                win_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            stage_cnt_q <= stage_cnt_d;
            stage_lst_q <= stage_lst_d;
            blk_lst_q   <= blk_lst_d;
            err_q       <= err_d;
            rnd_q       <= rnd_d;
            stage_q     <= stage_d;
            win_q       <= win_d;
        end
    end

    assign pad_ena_o   = stage_cnt_q != 5'd16;
    assign expnd_w_o   = win_q[0];
    assign expnd_w1_o  = win_q[0] ^ win_q[4];
    assign expnd_vld_o = state_q == EXPAND;
    assign expnd_rnd_o = rnd_q;
    assign expnd_sop_o = expnd_vld_o && rnd_q == 6'd0;
    assign expnd_lst_o = expnd_vld_o && rnd_q == 6'd63 && blk_lst_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_sm3_expnd_core.sv
// tb_sm3_expnd_core: randomized self-checking bench with a textbook SM3 expansion model.
module tb_sm3_expnd_core;
    typedef logic [31:0] blk_t [16];

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pad_d_i = '0;
    logic        pad_vld_i = 1'b0, pad_lst_i = 1'b0;
    logic        pad_ena_o, expnd_vld_o, expnd_sop_o, expnd_lst_o, err_o;
    logic [31:0] expnd_w_o, expnd_w1_o;
    logic [5:0]  expnd_rnd_o;

    int checks = 0, fails = 0, cyc = 0;
    logic [31:0] obs_w[$], obs_w1[$], exp_w[$], exp_w1[$];
    logic [5:0]  obs_rnd[$];
    bit          obs_sop[$], obs_lst[$], exp_sop[$], exp_lst[$];
    int          obs_cyc[$];

    sm3_expnd_core dut (
        .clk(clk), .rst_n(rst_n), .pad_d_i(pad_d_i), .pad_vld_i(pad_vld_i),
        .pad_lst_i(pad_lst_i), .pad_ena_o(pad_ena_o), .expnd_w_o(expnd_w_o),
        .expnd_w1_o(expnd_w1_o), .expnd_vld_o(expnd_vld_o), .expnd_rnd_o(expnd_rnd_o),
        .expnd_sop_o(expnd_sop_o), .expnd_lst_o(expnd_lst_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (expnd_vld_o === 1'b1) begin
            obs_w.push_back(expnd_w_o);
            obs_w1.push_back(expnd_w1_o);
            obs_rnd.push_back(expnd_rnd_o);
            obs_sop.push_back(expnd_sop_o);
            obs_lst.push_back(expnd_lst_o);
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference: standard SM3 expansion W_16..W_67 from one block, appended to the expected stream.
    task automatic add_block(input blk_t m, input bit fin);
        logic [31:0] w [68];
        logic [31:0] x;
        for (int j = 0; j < 16; j++) w[j] = m[j];
        for (int j = 16; j < 68; j++) begin
            x = w[j-16] ^ w[j-9] ^ rl(w[j-3], 15);
            w[j] = x ^ rl(x, 15) ^ rl(x, 23) ^ rl(w[j-13], 7) ^ w[j-6];
        end
        for (int j = 0; j < 64; j++) begin
            exp_w.push_back(w[j]);
            exp_w1.push_back(w[j] ^ w[j+4]);
            exp_sop.push_back(j == 0);
            exp_lst.push_back(fin && j == 63);
        end
    endtask

    task automatic rand_block(output blk_t m);
        for (int i = 0; i < 16; i++) m[i] = $urandom;
    endtask

    task automatic clear_q();
        obs_w.delete(); obs_w1.delete(); obs_rnd.delete(); obs_sop.delete();
        obs_lst.delete(); obs_cyc.delete(); exp_w.delete(); exp_w1.delete();
        exp_sop.delete(); exp_lst.delete();
    endtask

    task automatic do_reset();
        pad_vld_i = 1'b0; pad_lst_i = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_q();
    endtask

    task automatic put_word(input logic [31:0] d, input bit l);
        int t = 0;
        while (!pad_ena_o && t < 300) begin @(posedge clk); #1; t++; end
        if (!pad_ena_o) begin
            checks++; fails++;
            $display("FAIL put_word_timeout pad_ena_o=%b required 1", pad_ena_o);
        end
        pad_d_i = d; pad_vld_i = 1'b1; pad_lst_i = l;
        @(posedge clk); #1;
        pad_vld_i = 1'b0; pad_lst_i = 1'b0;
    endtask

    task automatic send_block(input blk_t m, input bit fin, input int gap);
        for (int i = 0; i < 16; i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            put_word(m[i], fin && i == 15);
        end
    endtask

    task automatic wait_rounds(input int n);
        int t = 0;
        while (obs_w.size() < n && t < 3000) begin @(posedge clk); #1; t++; end
        repeat (4) begin @(posedge clk); #1; end
        if (obs_w.size() < n) begin
            checks++; fails++;
            $display("FAIL wait_rounds got %0d rounds required %0d", obs_w.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({pad_ena_o, expnd_vld_o, expnd_sop_o, expnd_lst_o, err_o} !== 5'b10000 ||
            expnd_w_o !== 0 || expnd_w1_o !== 0 || expnd_rnd_o !== 0) begin
            fails++;
            $display("FAIL reset_in ena=%b vld=%b sop=%b lst=%b err=%b w=%h w1=%h rnd=%0d required ena=1 others 0",
                     pad_ena_o, expnd_vld_o, expnd_sop_o, expnd_lst_o, err_o, expnd_w_o, expnd_w1_o, expnd_rnd_o);
        end
        do_reset();
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if ({pad_ena_o, expnd_vld_o, expnd_sop_o, expnd_lst_o, err_o} !== 5'b10000 ||
            expnd_w_o !== 0 || expnd_w1_o !== 0 || expnd_rnd_o !== 0) begin
            fails++;
            $display("FAIL reset_idle ena=%b vld=%b err=%b w=%h rnd=%0d required ena=1 others 0",
                     pad_ena_o, expnd_vld_o, err_o, expnd_w_o, expnd_rnd_o);
        end
    endtask

    task automatic test_abc();
        blk_t m;
        m = '{default: 32'h0};
        m[0] = 32'h61626380; m[15] = 32'h00000018;
        do_reset();
        add_block(m, 1'b1);
        send_block(m, 1'b1, 0);
        wait_rounds(64);
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            fails++; $display("FAIL abc_count got %0d required %0d", obs_w.size(), exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            checks++;
            if (obs_w[k] !== exp_w[k] || obs_w1[k] !== exp_w1[k] || obs_rnd[k] !== 6'(k % 64) ||
                obs_sop[k] !== exp_sop[k] || obs_lst[k] !== exp_lst[k] || obs_cyc[k] != obs_cyc[0] + k) begin
                fails++;
                $display("FAIL abc_round k=%0d w=%h/%h w1=%h/%h rnd=%0d sop=%b/%b lst=%b/%b (got/required)",
                         k, obs_w[k], exp_w[k], obs_w1[k], exp_w1[k], obs_rnd[k], obs_sop[k], exp_sop[k], obs_lst[k], exp_lst[k]);
            end
        end
        if (obs_w.size() >= 64) begin
            checks++;
            if (obs_w[0] !== 32'h61626380 || obs_w1[0] !== 32'h61626380) begin
                fails++; $display("FAIL abc_r0 w=%h w1=%h required 61626380", obs_w[0], obs_w1[0]);
            end
            checks++;
            if (obs_w[16] !== 32'h9092E200 || obs_w1[12] !== 32'h9092E200) begin
                fails++; $display("FAIL abc_r16 w16=%h w1_12=%h required 9092e200", obs_w[16], obs_w1[12]);
            end
            checks++;
            if (obs_w[18] !== 32'h000C0606 || obs_w[19] !== 32'h719C70ED) begin
                fails++; $display("FAIL abc_r18_19 w18=%h w19=%h required 000c0606 719c70ed", obs_w[18], obs_w[19]);
            end
        end
        checks++;
        if (err_o !== 1'b0) begin fails++; $display("FAIL abc_err got %b required 0", err_o); end
    endtask

    task automatic test_back_to_back();
        blk_t a, b;
        do_reset();
        rand_block(a); rand_block(b);
        add_block(a, 1'b0); add_block(b, 1'b1);
        send_block(a, 1'b0, 0);
        send_block(b, 1'b1, 0);
        wait_rounds(128);
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            fails++; $display("FAIL b2b_count got %0d required %0d", obs_w.size(), exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            checks++;
            if (obs_w[k] !== exp_w[k] || obs_w1[k] !== exp_w1[k] || obs_rnd[k] !== 6'(k % 64) ||
                obs_sop[k] !== exp_sop[k] || obs_lst[k] !== exp_lst[k] || obs_cyc[k] != obs_cyc[0] + k) begin
                fails++;
                $display("FAIL b2b_round k=%0d w=%h/%h w1=%h/%h rnd=%0d sop=%b/%b lst=%b/%b cyc=%0d (got/required)",
                         k, obs_w[k], exp_w[k], obs_w1[k], exp_w1[k], obs_rnd[k], obs_sop[k], exp_sop[k], obs_lst[k], exp_lst[k], obs_cyc[k] - obs_cyc[0]);
            end
        end
        checks++;
        if (err_o !== 1'b0) begin fails++; $display("FAIL b2b_err got %b required 0", err_o); end
    endtask

    task automatic test_overflow();
        blk_t a, b;
        do_reset();
        rand_block(a); rand_block(b);
        add_block(a, 1'b0); add_block(b, 1'b1);
        send_block(a, 1'b0, 0);
        send_block(b, 1'b1, 0);
        checks++;
        if (pad_ena_o !== 1'b0) begin fails++; $display("FAIL ovf_ena got %b required 0", pad_ena_o); end
        pad_d_i = $urandom; pad_vld_i = 1'b1;
        @(posedge clk); #1;
        pad_vld_i = 1'b0;
        checks++;
        if (err_o !== 1'b1) begin fails++; $display("FAIL ovf_err got %b required 1", err_o); end
        checks++;
        if (pad_ena_o !== 1'b0) begin fails++; $display("FAIL ovf_ena_after got %b required 0", pad_ena_o); end
        wait_rounds(128);
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            fails++; $display("FAIL ovf_count got %0d required %0d", obs_w.size(), exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            checks++;
            if (obs_w[k] !== exp_w[k] || obs_w1[k] !== exp_w1[k] || obs_rnd[k] !== 6'(k % 64) ||
                obs_sop[k] !== exp_sop[k] || obs_lst[k] !== exp_lst[k] || obs_cyc[k] != obs_cyc[0] + k) begin
                fails++;
                $display("FAIL ovf_round k=%0d w=%h/%h w1=%h/%h rnd=%0d sop=%b/%b lst=%b/%b (got/required)",
                         k, obs_w[k], exp_w[k], obs_w1[k], exp_w1[k], obs_rnd[k], obs_sop[k], exp_sop[k], obs_lst[k], exp_lst[k]);
            end
        end
        checks++;
        if (err_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b required 1", err_o); end
    endtask

    task automatic test_bad_lst();
        blk_t m;
        do_reset();
        rand_block(m);
        for (int i = 0; i < 10; i++) put_word(m[i], i == 9);
        checks++;
        if (err_o !== 1'b1) begin fails++; $display("FAIL badlst_err got %b required 1", err_o); end
        for (int i = 10; i < 16; i++) put_word(m[i], 1'b0);
        repeat (100) begin @(posedge clk); #1; end
        checks++;
        if (err_o !== 1'b1) begin fails++; $display("FAIL badlst_sticky got %b required 1", err_o); end
    endtask

    task automatic test_reset_mid();
        blk_t a, b;
        int t = 0;
        do_reset();
        rand_block(a); rand_block(b);
        send_block(a, 1'b1, 0);
        @(negedge clk);
        while (!(expnd_vld_o === 1'b1 && expnd_rnd_o == 6'd30) && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (t >= 200) begin fails++; $display("FAIL rstmid_reach rnd=%0d required 30", expnd_rnd_o); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({pad_ena_o, expnd_vld_o, expnd_sop_o, expnd_lst_o, err_o} !== 5'b10000 ||
            expnd_w_o !== 0 || expnd_w1_o !== 0 || expnd_rnd_o !== 0) begin
            fails++;
            $display("FAIL rstmid_async ena=%b vld=%b err=%b w=%h w1=%h rnd=%0d required ena=1 others 0",
                     pad_ena_o, expnd_vld_o, err_o, expnd_w_o, expnd_w1_o, expnd_rnd_o);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_q();
        add_block(b, 1'b1);
        send_block(b, 1'b1, 0);
        wait_rounds(64);
        checks++;
        if (obs_w.size() != exp_w.size()) begin
            fails++; $display("FAIL rstmid_count got %0d required %0d", obs_w.size(), exp_w.size());
        end
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
            checks++;
            if (obs_w[k] !== exp_w[k] || obs_w1[k] !== exp_w1[k] || obs_rnd[k] !== 6'(k % 64) ||
                obs_sop[k] !== exp_sop[k] || obs_lst[k] !== exp_lst[k] || obs_cyc[k] != obs_cyc[0] + k) begin
                fails++;
                $display("FAIL rstmid_round k=%0d w=%h/%h w1=%h/%h rnd=%0d sop=%b/%b lst=%b/%b (got/required)",
                         k, obs_w[k], exp_w[k], obs_w1[k], exp_w1[k], obs_rnd[k], obs_sop[k], exp_sop[k], obs_lst[k], exp_lst[k]);
            end
        end
    endtask

    task automatic test_gaps();
        blk_t m;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            rand_block(m);
            add_block(m, 1'b1);
            send_block(m, 1'b1, 6);
            wait_rounds(64);
            checks++;
            if (obs_w.size() != exp_w.size()) begin
                fails++; $display("FAIL gaps_count run=%0d got %0d required %0d", r, obs_w.size(), exp_w.size());
            end
            for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++) begin
                checks++;
                if (obs_w[k] !== exp_w[k] || obs_w1[k] !== exp_w1[k] || obs_rnd[k] !== 6'(k % 64) ||
                    obs_sop[k] !== exp_sop[k] || obs_lst[k] !== exp_lst[k] || obs_cyc[k] != obs_cyc[0] + k) begin
                    fails++;
                    $display("FAIL gaps_round run=%0d k=%0d w=%h/%h w1=%h/%h rnd=%0d lst=%b/%b (got/required)",
                             r, k, obs_w[k], exp_w[k], obs_w1[k], exp_w1[k], obs_rnd[k], obs_lst[k], exp_lst[k]);
                end
            end
            checks++;
            if (err_o !== 1'b0) begin fails++; $display("FAIL gaps_err got %b required 0", err_o); end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_back_to_back();
        test_overflow();
        test_bad_lst();
        test_reset_mid();
        test_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
